rvcore_mem_responder: RTL and testbench

Memory-side responder for one RV core's instruction and data request ports. Accepts fetch, load and store requests from the core and arbitrates them onto a single 128-bit line-granular DRAM port. Returns 128-bit lines to the core with a busy handshake and keeps a one-entry instruction line buffer. On every completed store it emits a cache-invalidate pulse to the other harts.

---
 rtl/rvcore_mem_responder_pkg.sv | 15 +
 rtl/rvcore_mem_responder_if.sv | 37 +++
 rtl/rvcore_store_lane.sv | 19 +
 rtl/rvcore_mem_responder.sv | 118 +++++++++++
 tb/tb_rvcore_mem_responder.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/rvcore_mem_responder_pkg.sv
// rvcore_mem_responder_pkg: shared encodings for the memory responder
//   data ctrl codes, FSM states, line geometry, store decode helper
package rvcore_mem_responder_pkg;
    localparam int LINE_W   = 128;
    localparam int LINE_OFF = 4;
    localparam logic [2:0] CTRL_IDLE = 3'b000;
    localparam logic [2:0] CTRL_LOAD = 3'b001;
    localparam logic [2:0] CTRL_ST_B = 3'b100;
    localparam logic [2:0] CTRL_ST_H = 3'b101;
    localparam logic [2:0] CTRL_ST_W = 3'b110;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_R, S_DONE} state_e;
    function automatic logic is_store(input logic [2:0] c);
        return c == CTRL_ST_B || c == CTRL_ST_H || c == CTRL_ST_W;
    endfunction
endpackage

// File: rtl/rvcore_mem_responder_if.sv
// rvcore_mem_responder_if: core request/response and DRAM line port bundle
//   slave  = responder view, master = core + DRAM model view
interface rvcore_mem_responder_if;
    import rvcore_mem_responder_pkg::*;
    logic              i_insn_req;
    logic [31:0]       i_insn_addr;
    logic [2:0]        i_data_ctrl;
    logic [31:0]       i_data_addr;
    logic [31:0]       i_data_wdata;
    logic              i_flush;
    logic [LINE_W-1:0] o_insn_data;
    logic [LINE_W-1:0] o_data_data;
    logic              o_busy;
    logic              o_cache_invalidate;
    logic [31:0]       o_cache_invalidate_address;
    logic [31:0]       o_inv_hartid;
    logic              o_dram_req;
    logic              o_dram_we;
    logic [31:0]       o_dram_addr;
    logic [LINE_W-1:0] o_dram_wdata;
    logic [LINE_W/8-1:0] o_dram_wmask;
    logic              i_dram_ready;
    logic              i_dram_rvalid;
    logic [LINE_W-1:0] i_dram_rdata;
    modport slave (
        input  i_insn_req, i_insn_addr, i_data_ctrl, i_data_addr, i_data_wdata, i_flush,
               i_dram_ready, i_dram_rvalid, i_dram_rdata,
        output o_insn_data, o_data_data, o_busy, o_cache_invalidate, o_cache_invalidate_address,
               o_inv_hartid, o_dram_req, o_dram_we, o_dram_addr, o_dram_wdata, o_dram_wmask
    );
    modport master (
        output i_insn_req, i_insn_addr, i_data_ctrl, i_data_addr, i_data_wdata, i_flush,
               i_dram_ready, i_dram_rvalid, i_dram_rdata,
        input  o_insn_data, o_data_data, o_busy, o_cache_invalidate, o_cache_invalidate_address,
               o_inv_hartid, o_dram_req, o_dram_we, o_dram_addr, o_dram_wdata, o_dram_wmask
    );
endinterface

// File: rtl/rvcore_store_lane.sv
// rvcore_store_lane: places a right-aligned store into a 128-bit line
//   size_i (00 byte/01 half/10 word), addr_i line offset, wdata_i -> wdata_o line, wmask_o byte enables
module rvcore_store_lane
    import rvcore_mem_responder_pkg::*;
(
    input  logic [1:0]          size_i,
    input  logic [LINE_OFF-1:0] addr_i,
    input  logic [31:0]         wdata_i,
    output logic [LINE_W-1:0]   wdata_o,
    output logic [LINE_W/8-1:0] wmask_o
);
    logic [31:0] lane;
    // Replicating across every byte position lets the mask alone pick the target bytes.
    assign lane    = size_i == 2'b00 ? {4{wdata_i[7:0]}} : size_i == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
    assign wdata_o = {4{lane}};
    assign wmask_o = size_i == 2'b00 ? 16'h0001 << addr_i
                   : size_i == 2'b01 ? 16'h0003 << {addr_i[3:1], 1'b0}
                   : 16'h000F << {addr_i[3:2], 2'b00};
endmodule

// File: rtl/rvcore_mem_responder.sv
// rvcore_mem_responder: arbitrates fetch/load/store onto a 128-bit line DRAM port
//   CLK, RST_X (async active-low); bus: core requests, line responses, busy,
//   store invalidate pulse, DRAM request/response; one-entry fetch line buffer
module rvcore_mem_responder
    import rvcore_mem_responder_pkg::*;
#(
    parameter bit          IBUF_EN = 1'b1,
    parameter logic [31:0] MHARTID = 32'd0
) (
    input logic                   CLK,
    input logic                   RST_X,
    rvcore_mem_responder_if.slave bus
);
    state_e                state_q;
    logic                  is_insn_q, busy_q, req_q, we_q, inv_q, ibuf_valid_q;
    logic [31:0]           addr_q, inv_addr_q;
    logic [31-LINE_OFF:0]  ibuf_tag_q;
    logic [LINE_W-1:0]     wdata_q, insn_data_q, data_data_q, st_wdata_d;
    logic [LINE_W/8-1:0]   wmask_q, st_wmask_d;
    logic                  is_load, is_st, ibuf_hit;

    assign is_load  = bus.i_data_ctrl == CTRL_LOAD;
    assign is_st    = is_store(bus.i_data_ctrl);
    assign ibuf_hit = IBUF_EN && ibuf_valid_q && ibuf_tag_q == bus.i_insn_addr[31:LINE_OFF];

    rvcore_store_lane u_lane (
        .size_i  (bus.i_data_ctrl[1:0]),
        .addr_i  (bus.i_data_addr[LINE_OFF-1:0]),
        .wdata_i (bus.i_data_wdata),
        .wdata_o (st_wdata_d),
        .wmask_o (st_wmask_d)
    );

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q      <= S_IDLE;
            is_insn_q    <= 1'b0;
            busy_q       <= 1'b0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            inv_q        <= 1'b0;
            ibuf_valid_q <= 1'b0;
            addr_q       <= '0;
            inv_addr_q   <= '0;
            ibuf_tag_q   <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            insn_data_q  <= '0;
            data_data_q  <= '0;
        end else begin
            inv_q <= 1'b0;
            case (state_q)
                S_IDLE:
                    if (is_load || is_st) begin
                        is_insn_q <= 1'b0;
                        req_q     <= 1'b1;
                        busy_q    <= 1'b1;
                        we_q      <= is_st;
                        addr_q    <= {bus.i_data_addr[31:LINE_OFF], {LINE_OFF{1'b0}}};
                        wdata_q   <= is_st ? st_wdata_d : '0;
                        wmask_q   <= is_st ? st_wmask_d : '0;
                        state_q   <= S_ISSUE;
                    end else if (bus.i_insn_req && !ibuf_hit) begin
                        // On a hit nothing moves: o_insn_data is only ever written by
                        // fetch fills, so it already holds the buffered line.
                        is_insn_q <= 1'b1;
                        req_q     <= 1'b1;
                        busy_q    <= 1'b1;
                        we_q      <= 1'b0;
                        addr_q    <= {bus.i_insn_addr[31:LINE_OFF], {LINE_OFF{1'b0}}};
                        wdata_q   <= '0;
                        wmask_q   <= '0;
                        state_q   <= S_ISSUE;
                    end
                S_ISSUE:
                    if (bus.i_dram_ready) begin
                        req_q <= 1'b0;
                        if (we_q) begin
                            busy_q     <= 1'b0;
                            inv_q      <= 1'b1;
                            inv_addr_q <= addr_q;
                            state_q    <= S_DONE;
                            if (ibuf_tag_q == addr_q[31:LINE_OFF]) ibuf_valid_q <= 1'b0;
                        end else begin
                            state_q <= S_WAIT_R;
                        end
                    end
                S_WAIT_R:
                    if (bus.i_dram_rvalid) begin
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                        if (is_insn_q) begin
                            insn_data_q  <= bus.i_dram_rdata;
                            ibuf_tag_q   <= addr_q[31:LINE_OFF];
                            ibuf_valid_q <= IBUF_EN;
                        end else begin
                            data_data_q <= bus.i_dram_rdata;
                        end
                    end
                default: state_q <= S_IDLE;
            endcase
            // Flush wins over a fill landing on the same edge.
            if (bus.i_flush) ibuf_valid_q <= 1'b0;
        end
    end

    assign bus.o_insn_data                = insn_data_q;
    assign bus.o_data_data                = data_data_q;
    assign bus.o_busy                     = busy_q;
    assign bus.o_cache_invalidate         = inv_q;
    assign bus.o_cache_invalidate_address = inv_addr_q;
    assign bus.o_inv_hartid               = MHARTID;
    assign bus.o_dram_req                 = req_q;
    assign bus.o_dram_we                  = we_q;
    assign bus.o_dram_addr                = addr_q;
    assign bus.o_dram_wdata               = wdata_q;
    assign bus.o_dram_wmask               = wmask_q;
endmodule

// File: tb/tb_rvcore_mem_responder.sv
// tb_rvcore_mem_responder: directed self-checking bench for rvcore_mem_responder
module tb_rvcore_mem_responder;
    import rvcore_mem_responder_pkg::*;

    logic CLK = 1'b0;
    logic RST_X = 1'b0;
    int errors = 0;
    int checks = 0;

    rvcore_mem_responder_if bus ();

    rvcore_mem_responder #(.IBUF_EN(1'b1), .MHARTID(32'd3)) dut (
        .CLK   (CLK),
        .RST_X (RST_X),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    localparam logic [127:0] LA = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam logic [127:0] LB = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [127:0] expand(input logic [15:0] m);
        logic [127:0] e;
        for (int i = 0; i < 16; i++) e[i*8 +: 8] = {8{m[i]}};
        return e;
    endfunction

    task automatic idle_inputs;
        bus.i_insn_req    = 1'b0;
        bus.i_insn_addr   = '0;
        bus.i_data_ctrl   = CTRL_IDLE;
        bus.i_data_addr   = '0;
        bus.i_data_wdata  = '0;
        bus.i_flush       = 1'b0;
        bus.i_dram_ready  = 1'b0;
        bus.i_dram_rvalid = 1'b0;
        bus.i_dram_rdata  = '0;
    endtask

    // Full read transaction; rdly = extra cycles with ready held low.
    task automatic read_op(input bit insn, input logic [31:0] addr, input logic [127:0] rdata,
                           input int rdly, input bit flush_at_fill);
        logic [127:0] got;
        if (insn) begin bus.i_insn_req = 1'b1; bus.i_insn_addr = addr; end
        else begin bus.i_data_ctrl = CTRL_LOAD; bus.i_data_addr = addr; end
        step;
        bus.i_insn_req = 1'b0;
        bus.i_data_ctrl = CTRL_IDLE;
        checks++; if (bus.o_dram_req !== 1'b1) begin errors++; $display("FAIL rd_req addr=%h: got %b expected 1", addr, bus.o_dram_req); end
        checks++; if (bus.o_dram_addr !== {addr[31:4], 4'h0}) begin errors++; $display("FAIL rd_addr: got %h expected %h", bus.o_dram_addr, {addr[31:4], 4'h0}); end
        checks++; if (bus.o_dram_we !== 1'b0) begin errors++; $display("FAIL rd_we: got %b expected 0", bus.o_dram_we); end
        checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL rd_busy_t1: got %b expected 1", bus.o_busy); end
        for (int i = 0; i < rdly; i++) begin
            step;
            checks++; if (bus.o_dram_req !== 1'b1 || bus.o_dram_addr !== {addr[31:4], 4'h0} || bus.o_busy !== 1'b1)
                begin errors++; $display("FAIL rd_stall%0d: req=%b addr=%h busy=%b expected 1 %h 1", i, bus.o_dram_req, bus.o_dram_addr, bus.o_busy, {addr[31:4], 4'h0}); end
        end
        bus.i_dram_ready = 1'b1;
        step;
        bus.i_dram_ready = 1'b0;
        checks++; if (bus.o_dram_req !== 1'b0 || bus.o_busy !== 1'b1) begin errors++; $display("FAIL rd_wait: req=%b busy=%b expected 0 1", bus.o_dram_req, bus.o_busy); end
        bus.i_dram_rvalid = 1'b1;
        bus.i_dram_rdata = rdata;
        bus.i_flush = flush_at_fill;
        step;
        bus.i_dram_rvalid = 1'b0;
        bus.i_flush = 1'b0;
        got = insn ? bus.o_insn_data : bus.o_data_data;
        checks++; if (got !== rdata) begin errors++; $display("FAIL rd_data: got %h expected %h", got, rdata); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rd_busy_done: got %b expected 0", bus.o_busy); end
        step;
    endtask

    task automatic store_op(input logic [2:0] ctrl, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [15:0] exp_mask, input logic [127:0] exp_bytes);
        bus.i_data_ctrl = ctrl;
        bus.i_data_addr = addr;
        bus.i_data_wdata = wdata;
        step;
        bus.i_data_ctrl = CTRL_IDLE;
        checks++; if (bus.o_dram_req !== 1'b1 || bus.o_dram_we !== 1'b1) begin errors++; $display("FAIL st_req: req=%b we=%b expected 1 1", bus.o_dram_req, bus.o_dram_we); end
        checks++; if (bus.o_dram_addr !== {addr[31:4], 4'h0}) begin errors++; $display("FAIL st_addr: got %h expected %h", bus.o_dram_addr, {addr[31:4], 4'h0}); end
        checks++; if (bus.o_dram_wmask !== exp_mask) begin errors++; $display("FAIL st_mask: got %h expected %h", bus.o_dram_wmask, exp_mask); end
        checks++; if ((bus.o_dram_wdata & expand(exp_mask)) !== exp_bytes) begin errors++; $display("FAIL st_wdata: got %h expected %h", bus.o_dram_wdata & expand(exp_mask), exp_bytes); end
        checks++; if (bus.o_busy !== 1'b1 || bus.o_cache_invalidate !== 1'b0) begin errors++; $display("FAIL st_issue: busy=%b inv=%b expected 1 0", bus.o_busy, bus.o_cache_invalidate); end
        bus.i_dram_ready = 1'b1;
        step;
        bus.i_dram_ready = 1'b0;
        checks++; if (bus.o_busy !== 1'b0 || bus.o_dram_req !== 1'b0) begin errors++; $display("FAIL st_done: busy=%b req=%b expected 0 0", bus.o_busy, bus.o_dram_req); end
        checks++; if (bus.o_cache_invalidate !== 1'b1) begin errors++; $display("FAIL st_inv: got %b expected 1", bus.o_cache_invalidate); end
        checks++; if (bus.o_cache_invalidate_address !== {addr[31:4], 4'h0}) begin errors++; $display("FAIL st_inv_addr: got %h expected %h", bus.o_cache_invalidate_address, {addr[31:4], 4'h0}); end
        step;
        checks++; if (bus.o_cache_invalidate !== 1'b0) begin errors++; $display("FAIL st_inv_pulse: got %b expected 0", bus.o_cache_invalidate); end
    endtask

    task automatic ibuf_hit(input logic [31:0] addr, input logic [127:0] exp);
        bus.i_insn_req = 1'b1;
        bus.i_insn_addr = addr;
        for (int i = 0; i < 3; i++) begin
            step;
            checks++; if (bus.o_busy !== 1'b0 || bus.o_dram_req !== 1'b0 || bus.o_insn_data !== exp)
                begin errors++; $display("FAIL ibuf_hit%0d: busy=%b req=%b data=%h expected 0 0 %h", i, bus.o_busy, bus.o_dram_req, bus.o_insn_data, exp); end
        end
        bus.i_insn_req = 1'b0;
        step;
    endtask

    task automatic test_reset;
        idle_inputs();
        RST_X = 1'b0;
        #2;
        checks++; if (bus.o_busy !== 1'b0 || bus.o_dram_req !== 1'b0 || bus.o_cache_invalidate !== 1'b0)
            begin errors++; $display("FAIL reset_ctl: busy=%b req=%b inv=%b expected 0 0 0", bus.o_busy, bus.o_dram_req, bus.o_cache_invalidate); end
        checks++; if (bus.o_insn_data !== '0 || bus.o_data_data !== '0 || bus.o_dram_addr !== '0)
            begin errors++; $display("FAIL reset_data: insn=%h data=%h addr=%h expected 0", bus.o_insn_data, bus.o_data_data, bus.o_dram_addr); end
        checks++; if (bus.o_inv_hartid !== 32'd3) begin errors++; $display("FAIL reset_hartid: got %h expected 3", bus.o_inv_hartid); end
        step;
        step;
        RST_X = 1'b1;
        step;
    endtask

    task automatic test_load;
        read_op(1'b0, 32'h8000_1234, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 0, 1'b0);
    endtask

    task automatic test_store;
        store_op(CTRL_ST_W, 32'h8000_0108, 32'hDEAD_BEEF, 16'h0F00, 128'hDEAD_BEEF << 64);
        store_op(CTRL_ST_B, 32'h8000_0103, 32'h0000_00AB, 16'h0008, 128'hAB << 24);
        store_op(CTRL_ST_H, 32'h8000_0106, 32'h0000_1234, 16'h00C0, 128'h1234 << 48);
        store_op(CTRL_ST_H, 32'h8000_0107, 32'h0000_5678, 16'h00C0, 128'h5678 << 48);
        store_op(CTRL_ST_W, 32'h8000_000F, 32'h0BAD_F00D, 16'hF000, 128'h0BAD_F00D << 96);
    endtask

    task automatic test_ibuf;
        read_op(1'b1, 32'h4000_0010, LA, 0, 1'b0);
        ibuf_hit(32'h4000_0014, LA);
        read_op(1'b1, 32'h4000_0020, LB, 0, 1'b0);
        read_op(1'b1, 32'h4000_0010, LA, 0, 1'b0);
        ibuf_hit(32'h4000_001C, LA);
        store_op(CTRL_ST_B, 32'h4000_0018, 32'h0000_0011, 16'h0100, 128'h11 << 64);
        read_op(1'b1, 32'h4000_0010, LA, 0, 1'b0);
        ibuf_hit(32'h4000_0010, LA);
        bus.i_flush = 1'b1;
        step;
        bus.i_flush = 1'b0;
        read_op(1'b1, 32'h4000_0010, LB, 0, 1'b1);
        read_op(1'b1, 32'h4000_0010, LA, 0, 1'b0);
        ibuf_hit(32'h4000_0018, LA);
    endtask

    task automatic test_priority_stall;
        bus.i_data_ctrl = CTRL_LOAD;
        bus.i_data_addr = 32'h8000_2000;
        bus.i_insn_req = 1'b1;
        bus.i_insn_addr = 32'h4000_0100;
        step;
        bus.i_data_ctrl = CTRL_IDLE;
        checks++; if (bus.o_dram_addr !== 32'h8000_2000 || bus.o_dram_we !== 1'b0)
            begin errors++; $display("FAIL prio_load_first: addr=%h we=%b expected 80002000 0", bus.o_dram_addr, bus.o_dram_we); end
        for (int i = 0; i < 5; i++) begin
            step;
            checks++; if (bus.o_dram_req !== 1'b1 || bus.o_dram_addr !== 32'h8000_2000)
                begin errors++; $display("FAIL prio_stall%0d: req=%b addr=%h expected 1 80002000", i, bus.o_dram_req, bus.o_dram_addr); end
        end
        bus.i_dram_ready = 1'b1;
        step;
        bus.i_dram_ready = 1'b0;
        bus.i_dram_rvalid = 1'b1;
        bus.i_dram_rdata = LB;
        step;
        bus.i_dram_rvalid = 1'b0;
        checks++; if (bus.o_data_data !== LB || bus.o_busy !== 1'b0)
            begin errors++; $display("FAIL prio_load_done: data=%h busy=%b expected %h 0", bus.o_data_data, bus.o_busy, LB); end
        step;
        checks++; if (bus.o_dram_req !== 1'b0) begin errors++; $display("FAIL prio_done_plus1: req=%b expected 0", bus.o_dram_req); end
        step;
        bus.i_insn_req = 1'b0;
        checks++; if (bus.o_dram_req !== 1'b1 || bus.o_dram_addr !== 32'h4000_0100)
            begin errors++; $display("FAIL prio_fetch_next: req=%b addr=%h expected 1 40000100", bus.o_dram_req, bus.o_dram_addr); end
        bus.i_dram_ready = 1'b1;
        step;
        bus.i_dram_ready = 1'b0;
        bus.i_dram_rvalid = 1'b1;
        bus.i_dram_rdata = LA;
        step;
        bus.i_dram_rvalid = 1'b0;
        checks++; if (bus.o_insn_data !== LA) begin errors++; $display("FAIL prio_fetch_data: got %h expected %h", bus.o_insn_data, LA); end
        step;
    endtask

    task automatic test_reset_mid;
        bus.i_data_ctrl = CTRL_LOAD;
        bus.i_data_addr = 32'h8000_3000;
        step;
        bus.i_data_ctrl = CTRL_IDLE;
        bus.i_dram_ready = 1'b1;
        step;
        bus.i_dram_ready = 1'b0;
        RST_X = 1'b0;
        #1;
        checks++; if (bus.o_busy !== 1'b0 || bus.o_dram_req !== 1'b0 || bus.o_data_data !== '0 || bus.o_insn_data !== '0)
            begin errors++; $display("FAIL rstmid_outs: busy=%b req=%b data=%h insn=%h expected all 0", bus.o_busy, bus.o_dram_req, bus.o_data_data, bus.o_insn_data); end
        step;
        RST_X = 1'b1;
        bus.i_dram_rvalid = 1'b1;
        bus.i_dram_rdata = LB;
        step;
        bus.i_dram_rvalid = 1'b0;
        checks++; if (bus.o_data_data !== '0 || bus.o_busy !== 1'b0 || bus.o_dram_req !== 1'b0)
            begin errors++; $display("FAIL rstmid_stray: data=%h busy=%b req=%b expected 0 0 0", bus.o_data_data, bus.o_busy, bus.o_dram_req); end
        read_op(1'b0, 32'h8000_3004, LA, 1, 1'b0);
        read_op(1'b1, 32'h4000_0010, LB, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_ibuf();
        test_priority_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
